baud_gen_frac: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/frac_accum.sv | 35 +++
 rtl/baud_gen_frac.sv | 153 +++++++++++++++
 tb/tb_baud_gen_frac.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART baud generation path.
package uart_pkg;

    localparam int unsigned DIV_W_DEF  = 16;
    localparam int unsigned FRAC_W_DEF = 8;

    // Oversample index wide enough for any even BAUDCLOCK up to 256.
    localparam int unsigned OS_W = 8;
    typedef logic [OS_W-1:0] os_idx_t;

    // Reset divisor in fixed point: clock * 2^frac_w / (baudrate * baudclock), truncated.
    function automatic longint unsigned calc_rst_div(
        input longint unsigned clock,
        input longint unsigned baudrate,
        input longint unsigned baudclock,
        input int unsigned     frac_w
    );
        return (clock << frac_w) / (baudrate * baudclock);
    endfunction

endpackage

// File: rtl/frac_accum.sv
// Fractional phase accumulator; the carry stretches the following period by one clock.
module frac_accum
    import uart_pkg::*;
#(
    parameter int unsigned FRAC_W = FRAC_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clear,
    input  logic              load,
    input  logic              step,
    input  logic [FRAC_W-1:0] load_val,
    input  logic [FRAC_W-1:0] inc,
    output logic              carry
);

    logic [FRAC_W-1:0] acc;

    // Accumulator update: clear beats load beats step.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc   <= '0;
            carry <= 1'b0;
        end else if (clear) begin
            acc   <= '0;
            carry <= 1'b0;
        end else if (load) begin
            acc   <= load_val;
            carry <= 1'b0;
        end else if (step) begin
            {carry, acc} <= {1'b0, acc} + {1'b0, inc};
        end
    end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-N oversample tick generator with bit-centre and bit-end strobes.
module baud_gen_frac
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK     = 50000000,
    parameter int unsigned BAUDRATE  = 9600,
    parameter int unsigned BAUDCLOCK = 16,
    parameter int unsigned DIV_W     = DIV_W_DEF,
    parameter int unsigned FRAC_W    = FRAC_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              LOAD,
    input  logic [DIV_W-1:0]  DIV_INT,
    input  logic [FRAC_W-1:0] DIV_FRAC,
    input  logic              SYNC,
    output logic              BCLK,
    output logic              MID_TICK,
    output logic              BIT_TICK
);

    localparam int unsigned DW = DIV_W + FRAC_W;
    localparam logic [DW-1:0] RST_DIV = DW'(calc_rst_div(
        64'(CLOCK), 64'(BAUDRATE), 64'(BAUDCLOCK), FRAC_W));
    localparam logic [DIV_W-1:0]  RST_INT  = RST_DIV[DW-1:FRAC_W];
    localparam logic [FRAC_W-1:0] RST_FRAC = RST_DIV[FRAC_W-1:0];
    localparam os_idx_t OS_LAST = os_idx_t'(BAUDCLOCK - 1);
    localparam os_idx_t OS_MID  = os_idx_t'(BAUDCLOCK / 2 - 1);

    logic [DIV_W-1:0]  div_int_q,  div_int_d;
    logic [FRAC_W-1:0] div_frac_q, div_frac_d;
    logic [DIV_W-1:0]  pend_int_q,  pend_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic              pend_valid_q, pend_valid_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    os_idx_t           os_idx_q, os_idx_d;
    logic              bclk_d, mid_d, bit_d;

    logic              acc_clear, acc_step;
    logic              extra;
    logic [DIV_W-1:0]  eff_int;
    logic [DIV_W:0]    period_m1;
    logic              at_end;

    frac_accum #(
        .FRAC_W (FRAC_W)
    ) u_frac_accum (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (acc_clear),
        .load     (1'b0),
        .step     (acc_step),
        .load_val ('0),
        .inc      (div_frac_q),
        .carry    (extra)
    );

    // Period end detect; a zero integer divisor behaves as one.
    always_comb begin
        eff_int   = (div_int_q == '0) ? DIV_W'(1) : div_int_q;
        period_m1 = {1'b0, eff_int} + (DIV_W+1)'(extra) - (DIV_W+1)'(1);
        at_end    = ({1'b0, cnt_q} == period_m1);
    end

    // Next-state: SYNC restart, then EN gating, then normal counting.
    always_comb begin
        div_int_d    = div_int_q;
        div_frac_d   = div_frac_q;
        pend_int_d   = pend_int_q;
        pend_frac_d  = pend_frac_q;
        pend_valid_d = pend_valid_q;
        cnt_d        = cnt_q;
        os_idx_d     = os_idx_q;
        bclk_d       = 1'b0;
        mid_d        = 1'b0;
        bit_d        = 1'b0;
        acc_clear    = 1'b0;
        acc_step     = 1'b0;

        if (SYNC) begin
            cnt_d     = '0;
            os_idx_d  = '0;
            acc_clear = 1'b1;
            if (LOAD) begin
                div_int_d    = DIV_INT;
                div_frac_d   = DIV_FRAC;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                div_int_d    = pend_int_q;
                div_frac_d   = pend_frac_q;
                pend_valid_d = 1'b0;
            end
        end else if (!EN) begin
            // Frozen: a load takes effect at once and supersedes any pending value.
            if (LOAD) begin
                div_int_d    = DIV_INT;
                div_frac_d   = DIV_FRAC;
                pend_valid_d = 1'b0;
            end
        end else begin
            if (at_end) begin
                cnt_d    = '0;
                bclk_d   = 1'b1;
                mid_d    = (os_idx_q == OS_MID);
                bit_d    = (os_idx_q == OS_LAST);
                os_idx_d = (os_idx_q == OS_LAST) ? '0 : os_idx_q + os_idx_t'(1);
                acc_step = 1'b1;
                if (pend_valid_q) begin
                    div_int_d    = pend_int_q;
                    div_frac_d   = pend_frac_q;
                    pend_valid_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
            // Running: park the new divisor until the next tick boundary.
            if (LOAD) begin
                pend_int_d   = DIV_INT;
                pend_frac_d  = DIV_FRAC;
                pend_valid_d = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_int_q    <= RST_INT;
            div_frac_q   <= RST_FRAC;
            pend_int_q   <= '0;
            pend_frac_q  <= '0;
            pend_valid_q <= 1'b0;
            cnt_q        <= '0;
            os_idx_q     <= '0;
            BCLK         <= 1'b0;
            MID_TICK     <= 1'b0;
            BIT_TICK     <= 1'b0;
        end else begin
            div_int_q    <= div_int_d;
            div_frac_q   <= div_frac_d;
            pend_int_q   <= pend_int_d;
            pend_frac_q  <= pend_frac_d;
            pend_valid_q <= pend_valid_d;
            cnt_q        <= cnt_d;
            os_idx_q     <= os_idx_d;
            BCLK         <= bclk_d;
            MID_TICK     <= mid_d;
            BIT_TICK     <= bit_d;
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: expected tick spacing/strobes queued as stimulus is applied.
module tb_baud_gen_frac;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic        LOAD;
    logic [15:0] DIV_INT;
    logic [7:0]  DIV_FRAC;
    logic        SYNC;
    logic        BCLK;
    logic        MID_TICK;
    logic        BIT_TICK;

    baud_gen_frac dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .LOAD     (LOAD),
        .DIV_INT  (DIV_INT),
        .DIV_FRAC (DIV_FRAC),
        .SYNC     (SYNC),
        .BCLK     (BCLK),
        .MID_TICK (MID_TICK),
        .BIT_TICK (BIT_TICK)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int   gap;
        logic mid;
        logic bt;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;
    int   cyc = 0;
    int   last = 0;
    int   bclk_cnt = 0;
    int   mid_cnt = 0;
    int   bit_cnt = 0;
    int   h325 = 0;
    int   h326 = 0;
    int   exp_os = 0;
    int   sb_idx = 0;
    bit   sb_on = 1'b0;
    bit   last_valid = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Queue one expected tick; strobes follow the bench's own oversample position.
    task automatic push(input int gap);
        exp_t e;
        e.gap = gap;
        e.mid = (exp_os == 7);
        e.bt  = (exp_os == 15);
        exp_os = (exp_os + 1) % 16;
        sbq.push_back(e);
    endtask

    // One clock: sample after the edge, score any tick against the queue.
    task automatic tick();
        exp_t e;
        int   gap;
        @(posedge CLK);
        #1;
        cyc++;
        gap = cyc - last;
        if (BCLK) begin
            bclk_cnt++;
            if (MID_TICK) mid_cnt++;
            if (BIT_TICK) bit_cnt++;
            if (last_valid) begin
                if (gap == 325) h325++;
                if (gap == 326) h326++;
            end
            if (sb_on) begin
                if (sbq.size() == 0) begin
                    chk("bclk_unexpected", 64'(BCLK), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    sb_idx++;
                    chk($sformatf("gap#%0d", sb_idx), 64'(gap), 64'(e.gap));
                    chk($sformatf("mid#%0d", sb_idx), 64'(MID_TICK), 64'(e.mid));
                    chk($sformatf("bit#%0d", sb_idx), 64'(BIT_TICK), 64'(e.bt));
                end
            end
            last       = cyc;
            last_valid = 1'b1;
        end else if (MID_TICK || BIT_TICK) begin
            chk("orphan_strobe", 64'({MID_TICK, BIT_TICK}), 64'd0);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_drain"}, 64'(sbq.size()), 64'd0);
    endtask

    task automatic do_sync(input bit with_load, input int di, input int df);
        SYNC = 1'b1;
        if (with_load) begin
            LOAD     = 1'b1;
            DIV_INT  = 16'(di);
            DIV_FRAC = 8'(df);
        end
        tick();
        SYNC = 1'b0;
        LOAD = 1'b0;
        chk("sync_quiet", 64'({BCLK, MID_TICK, BIT_TICK}), 64'd0);
        last       = cyc;
        last_valid = 1'b1;
        exp_os     = 0;
    endtask

    initial begin
        int n;
        int n0;
        RST = 1'b1; EN = 1'b0; LOAD = 1'b0; SYNC = 1'b0;
        DIV_INT = '0; DIV_FRAC = '0;

        // Reset defaults: 325 + 133/256 clocks per tick.
        tick();
        tick();
        chk("rst_bclk", 64'(BCLK), 64'd0);
        chk("rst_mid", 64'(MID_TICK), 64'd0);
        chk("rst_bit", 64'(BIT_TICK), 64'd0);
        RST = 1'b0;
        EN  = 1'b1;
        bclk_cnt = 0; mid_cnt = 0; bit_cnt = 0; h325 = 0; h326 = 0;
        last_valid = 1'b0;
        for (int i = 0; i < 83333; i++) tick();
        chk("dflt_bclk_cnt", 64'(bclk_cnt), 64'd256);
        chk("dflt_mid_cnt", 64'(mid_cnt), 64'd16);
        chk("dflt_bit_cnt", 64'(bit_cnt), 64'd16);
        n = 0;
        while (bclk_cnt < 257 && n < 1000) begin
            tick();
            n++;
        end
        chk("dflt_pulse257", 64'(bclk_cnt), 64'd257);
        chk("dflt_p326", 64'(h326), 64'd133);
        chk("dflt_p325", 64'(h325), 64'd123);

        // Exact integer rate 4/0, loaded while running, applied by SYNC.
        LOAD = 1'b1; DIV_INT = 16'd4; DIV_FRAC = 8'd0;
        tick();
        LOAD = 1'b0;
        do_sync(1'b0, 0, 0);
        sb_on = 1'b1;
        for (int i = 0; i < 32; i++) push(4);
        drain("int4", 300);

        // Mid-period load: old 325 period completes, then spacing 10.
        do_sync(1'b1, 325, 0);
        push(325);
        for (int i = 0; i < 100; i++) tick();
        LOAD = 1'b1; DIV_INT = 16'd10; DIV_FRAC = 8'd0;
        tick();
        LOAD = 1'b0;
        for (int i = 0; i < 5; i++) push(10);
        drain("midload", 600);

        // Advance to oversample index 11, then SYNC mid-period.
        for (int i = 0; i < 5; i++) push(10);
        drain("to_os11", 200);
        for (int i = 0; i < 3; i++) tick();
        do_sync(1'b0, 0, 0);
        for (int i = 0; i < 8; i++) push(10);
        drain("resync", 200);

        // EN gap of 50 clocks four clocks into a period.
        for (int i = 0; i < 4; i++) tick();
        push(60);
        push(10);
        n0 = bclk_cnt;
        EN = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        chk("gap_quiet", 64'(bclk_cnt - n0), 64'd0);
        EN = 1'b1;
        drain("engap", 200);

        // EN gap with a direct 7/128 load inside it.
        for (int i = 0; i < 3; i++) tick();
        push(57);
        push(7); push(8); push(7); push(8); push(7);
        EN = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        LOAD = 1'b1; DIV_INT = 16'd7; DIV_FRAC = 8'd128;
        tick();
        LOAD = 1'b0;
        for (int i = 0; i < 29; i++) tick();
        EN = 1'b1;
        drain("gapload", 300);

        // Divisor 0/0 behaves as 1: tick every clock.
        do_sync(1'b1, 0, 0);
        for (int i = 0; i < 20; i++) push(1);
        drain("div0", 100);

        // Divisor 1/128: periods 1,1,2,1,2,...
        do_sync(1'b1, 1, 128);
        push(1); push(1); push(2); push(1); push(2); push(1); push(2); push(1);
        drain("div1h", 100);

        // Reset on the clock a tick would have fired; divisor returns to default.
        do_sync(1'b1, 10, 0);
        for (int i = 0; i < 9; i++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst2_bclk", 64'(BCLK), 64'd0);
        chk("rst2_mid", 64'(MID_TICK), 64'd0);
        chk("rst2_bit", 64'(BIT_TICK), 64'd0);
        last   = cyc;
        exp_os = 0;
        push(325); push(325); push(326);
        drain("rst2", 1200);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
